// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each transaction runs IDLE -> ACCESS -> RESP; out-of-range addresses skip ACCESS and answer with err.
module mem_arbiter #(
  parameter  int MEM_BYTES = 65536,
  localparam int WA        = $clog2(MEM_BYTES) - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_we,
  output logic          m0_ack,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_we,
  output logic          m1_ack,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          ram_en,
  output logic [WA-1:0] ram_addr,
  output logic [31:0]   ram_d,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prio;
  logic            r_port;
  logic [WA-1:0]   r_waddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_we;
  logic            r_ram_en;
  logic [3:0]      r_ram_we;
  logic            r_m0_ack;
  logic            r_m1_ack;
  logic            r_m0_err;
  logic            r_m1_err;
  logic            r_busy;

  logic            w_take;
  logic            w_grant;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_we;
  logic            w_oor;
  logic            w_port_nxt;
  logic            w_err_nxt;
  logic            w_resp_nxt;

  // r_prio names the port that wins a tie, so it always points away from the last grant.
  always_comb begin
    w_take      = 1'b0;
    w_state_nxt = r_state;
    w_grant     = (m0_req && m1_req) ? r_prio : m1_req;
    w_addr      = w_grant ? m1_addr  : m0_addr;
    w_wdata     = w_grant ? m1_wdata : m0_wdata;
    w_we        = w_grant ? m1_we    : m0_we;
    w_oor       = ({1'b0, w_addr} >= MEM_LIMIT);
    case (r_state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          w_take      = 1'b1;
          w_state_nxt = w_oor ? ST_RESP : ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    w_port_nxt = w_take ? w_grant : r_port;
    w_err_nxt  = w_take & w_oor;
    w_resp_nxt = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_port   <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= 32'h0;
      r_we     <= 4'b0000;
      r_ram_en <= 1'b0;
      r_ram_we <= 4'b0000;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (w_take) begin
        r_prio  <= ~w_grant;
        r_port  <= w_grant;
        r_waddr <= w_addr[WA+1:2];
        r_wdata <= w_wdata;
        r_we    <= w_we;
      end
      r_ram_en <= (w_state_nxt == ST_ACCESS);
      r_ram_we <= (w_state_nxt == ST_ACCESS) ? w_we : 4'b0000;
      r_m0_ack <= w_resp_nxt & ~w_port_nxt;
      r_m1_ack <= w_resp_nxt &  w_port_nxt;
      r_m0_err <= w_resp_nxt & ~w_port_nxt & w_err_nxt;
      r_m1_err <= w_resp_nxt &  w_port_nxt & w_err_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  // ram_q only becomes valid in the RESP cycle, so read data is gated rather than registered.
  assign m0_rdata = (r_m0_ack && !r_m0_err && (r_we == 4'b0000)) ? ram_q : 32'h0;
  assign m1_rdata = (r_m1_ack && !r_m1_err && (r_we == 4'b0000)) ? ram_q : 32'h0;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_err   = r_m0_err;
  assign m1_err   = r_m1_err;
  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_waddr;
  assign ram_d    = r_wdata;
  assign busy     = r_busy;

endmodule
